// File: rtl/grf_writeback.sv
// grf_writeback: 32x32-bit general register file for the single-cycle MIPS datapath.
// Sits downstream of the write-data select mux and feeds the decode/ALU side.
//
// Parameters:
//   BYPASS - 1: a same-cycle write to a read address forwards WD onto that read port
//            0: read ports show stored contents only
//   TRACE  - 1: print a trace line on every write-enabled clock edge (simulation only)
//
// Ports:
//   clk    - system clock, state updates on the rising edge
//   reset  - asynchronous active-high reset, clears every register
//   WE     - write enable
//   A1, A2 - read addresses (rs, rt)
//   A3     - write address
//   WD     - write data
//   pc     - PC of the writing instruction, used by the trace only
//   RD1    - combinational read data for A1
//   RD2    - combinational read data for A2
module grf_writeback #(
  parameter bit BYPASS = 1'b0,
  parameter bit TRACE  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WE,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic [31:0] WD,
  input  logic [31:0] pc,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];

  // A write only qualifies for a non-zero destination. WE is tested first so
  // an X/Z address or data with WE=0 cannot reach the storage.
  logic wr_en;
  assign wr_en = WE && (A3 != 5'd0);

  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[A3] = WD;
    end
    // $0 is hardwired; keep its storage at zero regardless of the decode above.
    regs_d[0] = 32'h0000_0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: 32'h0000_0000};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports: stored value, optionally overridden by a same-cycle write.
  // Reset forces zero so a forwarded WD cannot leak out while clearing.
  always_comb begin
    RD1 = (A1 == 5'd0) ? 32'h0000_0000 : regs_q[A1];
    if (BYPASS && wr_en && (A1 == A3)) begin
      RD1 = WD;
    end
    if (reset) begin
      RD1 = 32'h0000_0000;
    end
  end

  always_comb begin
    RD2 = (A2 == 5'd0) ? 32'h0000_0000 : regs_q[A2];
    if (BYPASS && wr_en && (A2 == A3)) begin
      RD2 = WD;
    end
    if (reset) begin
      RD2 = 32'h0000_0000;
    end
  end

`ifndef SYNTHESIS
  // Write trace; printed for A3=0 too, since the instruction did issue a write.
  if (TRACE) begin : g_trace
    always @(posedge clk) begin
      if (!reset && WE) begin
        $display("@%h: $%d <= %h", pc, A3, WD);
      end
    end
  end
`endif

endmodule

// File: tb/tb_grf_writeback.sv
// Self-checking bench for grf_writeback. Two instances share the stimulus:
// u_nobyp (BYPASS=0, TRACE=1) and u_byp (BYPASS=1, TRACE=0).
module tb_grf_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        WE;
  logic [4:0]  A1, A2, A3;
  logic [31:0] WD, pc;
  logic [31:0] rd1_nb, rd2_nb, rd1_b, rd2_b;

  int checks = 0;
  int errors = 0;

  // Architectural view of the register file: what each register should hold.
  logic [31:0] model [32];

  always #5 clk = ~clk;

  grf_writeback #(.BYPASS(1'b0), .TRACE(1'b1)) u_nobyp (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .pc(pc), .RD1(rd1_nb), .RD2(rd2_nb)
  );

  grf_writeback #(.BYPASS(1'b1), .TRACE(1'b0)) u_byp (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .pc(pc), .RD1(rd1_b), .RD2(rd2_b)
  );

  // Value a read port must show right now, from the register-file rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (reset === 1'b1) return 32'h0;
    if (byp && (WE === 1'b1) && (A3 != 5'd0) && (a == A3)) return WD;
    if (a == 5'd0) return 32'h0;
    return model[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Advance one rising edge; the model takes the write seen at that edge.
  task automatic tick();
    @(posedge clk);
    if (reset !== 1'b1 && WE === 1'b1 && A3 != 5'd0) model[A3] = WD;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; WE = 1'b0; A1 = 5'd5; A2 = 5'd31; A3 = 5'd0; WD = 32'h0; pc = 32'h0;
    clear_model();
    #2;
    checks += 4;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL reset_rd1_nb got %h exp 0", rd1_nb); end
    if (rd2_nb !== 32'h0) begin errors++; $display("FAIL reset_rd2_nb got %h exp 0", rd2_nb); end
    if (rd1_b  !== 32'h0) begin errors++; $display("FAIL reset_rd1_b got %h exp 0", rd1_b); end
    if (rd2_b  !== 32'h0) begin errors++; $display("FAIL reset_rd2_b got %h exp 0", rd2_b); end
    // Write attempt during reset: no forwarding, no storage.
    WE = 1'b1; A3 = 5'd7; WD = 32'h0000_5555; A1 = 5'd7; A2 = 5'd7;
    #1;
    checks++;
    if (rd1_b !== 32'h0) begin errors++; $display("FAIL reset_nofwd got %h exp 0", rd1_b); end
    tick();
    checks++;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL reset_priority got %h exp 0", rd1_nb); end
    // Release mid-cycle with WE=1: storage waits for the next edge.
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL release_nowrite got %h exp 0", rd1_nb); end
    if (rd1_b !== 32'h0000_5555) begin
      errors++; $display("FAIL release_fwd got %h exp 00005555", rd1_b);
    end
    tick();
    WE = 1'b0;
    #1;
    checks++;
    if (rd1_nb !== 32'h0000_5555) begin
      errors++; $display("FAIL release_write got %h exp 00005555", rd1_nb);
    end
  endtask

  task automatic test_reset_mid();
    WE = 1'b1; A3 = 5'd5; WD = 32'hDEAD_BEEF; A1 = 5'd5; A2 = 5'd7;
    tick();
    WE = 1'b0;
    #1;
    checks++;
    if (rd1_nb !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL pre_reset got %h exp deadbeef", rd1_nb);
    end
    #1 reset = 1'b1;
    clear_model();
    #1;
    checks += 3;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL async_clear_nb got %h exp 0", rd1_nb); end
    if (rd1_b  !== 32'h0) begin errors++; $display("FAIL async_clear_b got %h exp 0", rd1_b); end
    if (rd2_nb !== 32'h0) begin errors++; $display("FAIL async_clear_r7 got %h exp 0", rd2_nb); end
    #1 reset = 1'b0;
    tick();
    checks++;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL stays_clear got %h exp 0", rd1_nb); end
  endtask

  task automatic test_basic();
    WE = 1'b1; A3 = 5'd8; WD = 32'h1234_5678; pc = 32'h0000_3000;
    tick();
    WE = 1'b0; A1 = 5'd8; A2 = 5'd8;
    #1;
    checks += 4;
    if (rd1_nb !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd1_nb got %h exp 12345678", rd1_nb); end
    if (rd2_nb !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd2_nb got %h exp 12345678", rd2_nb); end
    if (rd1_b  !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd1_b got %h exp 12345678", rd1_b); end
    if (rd2_b  !== 32'h1234_5678) begin errors++; $display("FAIL basic_rd2_b got %h exp 12345678", rd2_b); end
  endtask

  task automatic test_zero();
    WE = 1'b1; A3 = 5'd0; WD = 32'hFFFF_FFFF; A1 = 5'd0; A2 = 5'd1; pc = 32'h0000_3004;
    #1;
    checks++;
    if (rd1_b !== 32'h0) begin errors++; $display("FAIL zero_nofwd got %h exp 0", rd1_b); end
    tick();
    WE = 1'b0;
    #1;
    checks += 3;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL zero_r0 got %h exp 0", rd1_nb); end
    if (rd2_nb !== 32'h0) begin errors++; $display("FAIL zero_r1 got %h exp 0", rd2_nb); end
    if (rd1_b  !== 32'h0) begin errors++; $display("FAIL zero_r0_b got %h exp 0", rd1_b); end
    A1 = 5'd31; A2 = 5'd8;
    #1;
    checks += 2;
    if (rd1_nb !== 32'h0) begin errors++; $display("FAIL zero_r31 got %h exp 0", rd1_nb); end
    if (rd2_nb !== 32'h1234_5678) begin errors++; $display("FAIL zero_r8 got %h exp 12345678", rd2_nb); end
  endtask

  task automatic test_read_during_write();
    WE = 1'b1; A3 = 5'd9; WD = 32'h11;
    tick();
    WD = 32'h22; A1 = 5'd9; A2 = 5'd10;
    #1;
    checks += 4;
    if (rd1_nb !== 32'h11) begin errors++; $display("FAIL rdw_before_nb got %h exp 11", rd1_nb); end
    if (rd1_b  !== 32'h22) begin errors++; $display("FAIL rdw_before_b got %h exp 22", rd1_b); end
    if (rd2_b  !== 32'h0)  begin errors++; $display("FAIL rdw_other_b got %h exp 0", rd2_b); end
    if (rd2_nb !== 32'h0)  begin errors++; $display("FAIL rdw_other_nb got %h exp 0", rd2_nb); end
    tick();
    WE = 1'b0;
    #1;
    checks += 2;
    if (rd1_nb !== 32'h22) begin errors++; $display("FAIL rdw_after_nb got %h exp 22", rd1_nb); end
    if (rd1_b  !== 32'h22) begin errors++; $display("FAIL rdw_after_b got %h exp 22", rd1_b); end
    // Both ports on the written register forward together.
    WE = 1'b1; A3 = 5'd12; WD = 32'h0BAD_F00D; A1 = 5'd12; A2 = 5'd12;
    #1;
    checks += 2;
    if (rd1_b !== 32'h0BAD_F00D) begin errors++; $display("FAIL dual_fwd_rd1 got %h exp 0badf00d", rd1_b); end
    if (rd2_b !== 32'h0BAD_F00D) begin errors++; $display("FAIL dual_fwd_rd2 got %h exp 0badf00d", rd2_b); end
    tick();
    WE = 1'b0;
  endtask

  task automatic test_jal();
    WE = 1'b1; A3 = 5'd31; WD = 32'h0000_3008; pc = 32'h0000_3004;
    tick();
    WE = 1'b0; WD = 32'hAAAA_AAAA; A2 = 5'd31;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks += 2;
      if (rd2_nb !== 32'h0000_3008) begin errors++; $display("FAIL jal_nb[%0d] got %h exp 00003008", i, rd2_nb); end
      if (rd2_b  !== 32'h0000_3008) begin errors++; $display("FAIL jal_b[%0d] got %h exp 00003008", i, rd2_b); end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1n, e2n, e1b, e2b;
    for (int it = 0; it < 400; it++) begin
      WE = 1'($urandom_range(0, 1));
      A1 = 5'($urandom); A2 = 5'($urandom); A3 = 5'($urandom);
      if ($urandom_range(0, 3) == 0) A1 = A3;
      if ($urandom_range(0, 3) == 0) A2 = A3;
      WD = $urandom; pc = $urandom & 32'hFFFF_FFFC;
      if (!WE && $urandom_range(0, 3) == 0) begin A3 = 'x; WD = 'x; end
      #1;
      e1n = exp_rd(A1, 1'b0); e2n = exp_rd(A2, 1'b0);
      e1b = exp_rd(A1, 1'b1); e2b = exp_rd(A2, 1'b1);
      checks += 4;
      if (rd1_nb !== e1n) begin errors++; $display("FAIL rand_rd1_nb[%0d] a=%0d got %h exp %h", it, A1, rd1_nb, e1n); end
      if (rd2_nb !== e2n) begin errors++; $display("FAIL rand_rd2_nb[%0d] a=%0d got %h exp %h", it, A2, rd2_nb, e2n); end
      if (rd1_b  !== e1b) begin errors++; $display("FAIL rand_rd1_b[%0d] a=%0d got %h exp %h", it, A1, rd1_b, e1b); end
      if (rd2_b  !== e2b) begin errors++; $display("FAIL rand_rd2_b[%0d] a=%0d got %h exp %h", it, A2, rd2_b, e2b); end
      tick();
      if (it % 150 == 149) begin
        #1 reset = 1'b1;
        clear_model();
        #1;
        checks++;
        if (rd1_nb !== 32'h0) begin errors++; $display("FAIL rand_reset got %h exp 0", rd1_nb); end
        reset = 1'b0;
      end
    end
    WE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_basic();
    test_zero();
    test_read_during_write();
    test_jal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grf_writeback.md
Name: grf_writeback

Overview:
- 32x32-bit general register file for the single-cycle MIPS datapath.
- Sits directly downstream of the write-data select mux. It consumes the selected Wdata (ALU result, DM read data or PC+4) at the write port.
- Provides two combinational read ports to the decode/ALU side.
- Emits a simulation write trace for each accepted write.

Parameters:
- BYPASS, 0, 1 = a same-cycle write to a read address forwards WD onto that read port; 0 = read ports show stored contents only.
- TRACE, 1, 1 = $display a line on every write-enabled clock edge; 0 = silent.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all registers
- WE  input  1  write enable from the control unit
- A1  input  5  read port 1 address (rs)
- A2  input  5  read port 2 address (rt)
- A3  input  5  write address (rd/rt/$31, already selected upstream)
- WD  input  32  write data, the output of the write-data select mux
- pc  input  32  PC of the instruction performing the write; used for the trace only
- RD1  output  32  read data for A1
- RD2  output  32  read data for A2

Behaviour:
- Storage: 32 registers of 32 bits, indices 0..31.
- Reset:
  - Assertion of reset clears all 32 registers to 32'h0000_0000 immediately, without waiting for clk.
  - reset has priority over any write on the same edge.
  - Deasserting reset while WE=1 has no effect until the next rising clk edge.
- Write:
  - At the rising clk edge, if reset=0 and WE=1 and A3!=0, reg[A3] <= WD.
  - Writes to A3=0 are discarded. reg[0] reads as 0 at all times.
  - WE=0 leaves all registers unchanged.
- Read:
  - Purely combinational; zero-cycle latency.
  - RD1 = (A1==0) ? 0 : reg[A1]. RD2 is the same for A2.
  - During reset, RD1=RD2=0.
- Bypass when BYPASS=1:
  - If WE=1, A3!=0 and A1==A3, then RD1=WD in the same cycle. RD2 follows the same rule with A2.
  - When A1==A2==A3, both ports forward.
- Bypass when BYPASS=0: the written value appears on the read ports only after the rising edge.
- Simultaneous read/write of the same register:
  - BYPASS=0: RD shows the old value before the edge and the new value after it.
  - BYPASS=1: RD shows WD before the edge and the stored WD after it.
- Trace when TRACE=1:
  - On every rising edge with reset=0 and WE=1, print "@%h: $%d <= %h" with pc, A3, WD.
  - The line prints for A3=0 as well; the register still stays 0.
  - No trace line while reset=1.
- Widths: no arithmetic. Addresses index directly; X/Z on unused inputs must not corrupt state when WE=0.

Test Plan:
1. Reset/clear: write 32'hDEAD_BEEF to $5, then pulse reset mid-cycle (not on an edge) -> RD1 with A1=5 reads 0 immediately, before the next clk edge.
2. Basic write/read: WE=1, A3=8, WD=32'h1234_5678, pc=32'h0000_3000; one edge; then A1=8, A2=8 -> RD1=RD2=32'h1234_5678; trace "@00003000: $ 8 <= 12345678".
3. $0 immunity: WE=1, A3=0, WD=32'hFFFF_FFFF; edge -> RD1 with A1=0 is 0. Trace line is still printed. No other register changes (spot-check $1 and $31 still 0).
4. Read-during-write, BYPASS=0: $9=32'h11 stored. Drive WE=1, A3=9, WD=32'h22, A1=9 -> RD1=32'h11 before the edge, 32'h22 after.
5. Read-during-write, BYPASS=1: same stimulus -> RD1=32'h22 before the edge. RD2 with A2=10 is unaffected.
6. jal link path: WE=1, A3=31, WD=32'h0000_3008; edge; then WE=0 with WD changed to 32'hAAAA_AAAA -> RD2 with A2=31 stays 32'h0000_3008 across 3 further edges.
